pc_fetch_unit: RTL and testbench

- Program-counter and fetch-sequencing stage directly upstream of the instruction ROM.
- Holds the current word address (PC) and drives it to the ROM address input each cycle.
- Computes the next PC from sequential, branch, or jump control supplied by the controller and ALU.
- Runs a small run/halt/fault state machine and keeps a retired-instruction counter for test benches.

---
 rtl/pc_fetch_unit_pkg.sv | 18 +
 rtl/pc_fetch_unit_if.sv | 34 +++
 rtl/pc_fetch_unit_pc_next_sel.sv | 35 +++
 rtl/pc_fetch_unit.sv | 108 ++++++++++
 tb/tb_pc_fetch_unit.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the instruction ROM:
// FSM state encoding and the default address-space constants.
package pc_fetch_unit_pkg;

  // Fetch-stage run state. The encoding is fixed so that debug tooling can
  // decode it directly.
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_FAULT  = 2'b10
  } fetchState_t;

  // Defaults shared with the instruction ROM so both agree on the address map.
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_IMEM_DEPTH = 32;
  localparam int DEF_CNT_W      = 32;

endpackage : pc_fetch_unit_pkg

// File: rtl/pc_fetch_unit_if.sv
// Control/status bundle between the controller/ALU (master) and the
// fetch stage (slave).
interface pc_fetch_unit_if #(
  parameter int ADDR_W = pc_fetch_unit_pkg::DEF_ADDR_W,
  parameter int CNT_W  = pc_fetch_unit_pkg::DEF_CNT_W
) ();

  // Redirect / sequencing controls
  logic              Stall;
  logic              BranchTaken;
  logic [ADDR_W-1:0] BranchOff;
  logic              JumpEn;
  logic [ADDR_W-1:0] JumpTarget;
  logic              Halt;
  logic              Resume;

  // Fetch-stage status
  logic [ADDR_W-1:0] PCOut;
  logic [ADDR_W-1:0] PCPlus1;
  logic              Running;
  logic              Fault;
  logic [CNT_W-1:0]  RetireCnt;

  modport master (
    output Stall, BranchTaken, BranchOff, JumpEn, JumpTarget, Halt, Resume,
    input  PCOut, PCPlus1, Running, Fault, RetireCnt
  );

  modport slave (
    input  Stall, BranchTaken, BranchOff, JumpEn, JumpTarget, Halt, Resume,
    output PCOut, PCPlus1, Running, Fault, RetireCnt
  );

endinterface : pc_fetch_unit_if

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Next-PC selection: jump over branch over sequential, plus the ROM range
// check on the selected address. Purely combinational.
module pc_next_sel #(
  parameter int ADDR_W     = pc_fetch_unit_pkg::DEF_ADDR_W,
  parameter int IMEM_DEPTH = pc_fetch_unit_pkg::DEF_IMEM_DEPTH
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              seqOnly,     // force PC+1 (used when leaving HALTED)
  input  logic              jumpEn,
  input  logic [ADDR_W-1:0] jumpTarget,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] branchOff,
  output logic [ADDR_W-1:0] nextPc,
  output logic              outOfRange
);

  // One extra bit so a depth equal to 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(IMEM_DEPTH);

  // Priority select; the branch add wraps modulo 2^ADDR_W by truncation.
  always_comb begin
    nextPc = pc + ADDR_W'(1);
    if (!seqOnly) begin
      if (jumpEn) begin
        nextPc = jumpTarget;
      end else if (branchTaken) begin
        nextPc = pc + branchOff;
      end
    end
  end

  // Unsigned range check against the ROM size.
  assign outOfRange = ({1'b0, nextPc} >= DEPTH_EXT);

endmodule : pc_next_sel

// File: rtl/pc_fetch_unit.sv
// Program counter, run/halt/fault sequencing and retired-instruction
// counter for the stage feeding the instruction ROM address.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter int              CNT_W      = DEF_CNT_W
) (
  input logic             Clk,
  input logic             Rst,
  pc_fetch_unit_if.slave  bus
);

  fetchState_t       stateReg, stateNext;
  logic [ADDR_W-1:0] pcReg, pcNext;
  logic [CNT_W-1:0]  cntReg, cntNext;
  logic              retire;

  logic [ADDR_W-1:0] selPc;
  logic              selOutOfRange;
  logic              seqOnly;

  // Outside RUN the only way forward is Resume to PC+1, so redirects are masked.
  assign seqOnly = (stateReg != ST_RUN);

  pc_next_sel #(
    .ADDR_W     (ADDR_W),
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_nextSel (
    .pc          (pcReg),
    .seqOnly     (seqOnly),
    .jumpEn      (bus.JumpEn),
    .jumpTarget  (bus.JumpTarget),
    .branchTaken (bus.BranchTaken),
    .branchOff   (bus.BranchOff),
    .nextPc      (selPc),
    .outOfRange  (selOutOfRange)
  );

  // State, PC and counter registers; reset overrides everything.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stateReg <= ST_RUN;
      pcReg    <= RESET_PC;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      pcReg    <= pcNext;
      cntReg   <= cntNext;
    end
  end

  // Next-state, next-PC and retire decision.
  always_comb begin
    stateNext = stateReg;
    pcNext    = pcReg;
    retire    = 1'b0;
    unique case (stateReg)
      ST_RUN: begin
        if (bus.Halt) begin
          // The halt instruction itself retires; PC stays on it.
          stateNext = ST_HALTED;
          retire    = 1'b1;
        end else if (bus.Stall) begin
          // Hold; redirects are ignored while stalled.
        end else if (selOutOfRange) begin
          stateNext = ST_FAULT;
        end else begin
          pcNext = selPc;
          retire = 1'b1;
        end
      end
      ST_HALTED: begin
        if (bus.Resume) begin
          if (selOutOfRange) begin
            stateNext = ST_FAULT;
          end else begin
            stateNext = ST_RUN;
            pcNext    = selPc;
          end
        end
      end
      ST_FAULT: begin
        // Sticky until reset.
      end
      default: begin
        stateNext = ST_FAULT;
      end
    endcase
  end

  // Saturating retire counter.
  always_comb begin
    cntNext = cntReg;
    if (retire && (cntReg != {CNT_W{1'b1}})) begin
      cntNext = cntReg + CNT_W'(1);
    end
  end

  assign bus.PCOut     = pcReg;
  assign bus.PCPlus1   = pcReg + ADDR_W'(1);
  assign bus.Running   = (stateReg == ST_RUN);
  assign bus.Fault     = (stateReg == ST_FAULT);
  assign bus.RetireCnt = cntReg;

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with hand-computed expectations.
module tb_pc_fetch_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pc_fetch_unit_if #(.ADDR_W(32), .CNT_W(32)) bus ();

  pc_fetch_unit #(
    .ADDR_W     (32),
    .RESET_PC   (32'd0),
    .IMEM_DEPTH (32),
    .CNT_W      (32)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s value=%0h", tag, obs);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearCtl();
    bus.Stall       = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.BranchOff   = '0;
    bus.JumpEn      = 1'b0;
    bus.JumpTarget  = '0;
    bus.Halt        = 1'b0;
    bus.Resume      = 1'b0;
  endtask

  task automatic jumpTo(input logic [31:0] tgt);
    clearCtl();
    bus.JumpEn     = 1'b1;
    bus.JumpTarget = tgt;
    step();
    clearCtl();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clearCtl();
    rst = 1'b1;
    step();
    step();
    checkVal("rst_pc",      bus.PCOut, 32'd0);
    checkVal("rst_running", 32'(bus.Running), 32'd1);
    checkVal("rst_fault",   32'(bus.Fault), 32'd0);
    checkVal("rst_cnt",     bus.RetireCnt, 32'd0);
    rst = 1'b0;

    // Free-running sequence 1..5
    for (int i = 1; i <= 5; i++) begin
      step();
      checkVal($sformatf("seq_pc%0d", i), bus.PCOut, 32'(i));
    end
    checkVal("seq_cnt",     bus.RetireCnt, 32'd5);
    checkVal("seq_running", 32'(bus.Running), 32'd1);
    checkVal("seq_plus1",   bus.PCPlus1, 32'd6);

    // Walk to 7, then branch by -2
    step();
    step();
    checkVal("pc7", bus.PCOut, 32'd7);
    bus.BranchTaken = 1'b1;
    bus.BranchOff   = 32'hFFFF_FFFE;
    step();
    clearCtl();
    checkVal("br_neg_pc",  bus.PCOut, 32'd5);
    checkVal("br_neg_cnt", bus.RetireCnt, 32'd8);

    // Jump beats branch
    jumpTo(32'd3);
    checkVal("jmp3_pc", bus.PCOut, 32'd3);
    bus.JumpEn      = 1'b1;
    bus.JumpTarget  = 32'd9;
    bus.BranchTaken = 1'b1;
    bus.BranchOff   = 32'd4;
    step();
    clearCtl();
    checkVal("jmp_prio_pc",  bus.PCOut, 32'd9);
    checkVal("jmp_prio_cnt", bus.RetireCnt, 32'd10);

    // Stall masks a pending jump
    jumpTo(32'd4);
    bus.Stall      = 1'b1;
    bus.JumpEn     = 1'b1;
    bus.JumpTarget = 32'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal($sformatf("stall_pc%0d", i), bus.PCOut, 32'd4);
    end
    checkVal("stall_cnt", bus.RetireCnt, 32'd11);
    bus.Stall = 1'b0;
    step();
    clearCtl();
    checkVal("unstall_pc",  bus.PCOut, 32'd0);
    checkVal("unstall_cnt", bus.RetireCnt, 32'd12);

    // Halt at 9, redirects ignored while halted, then resume
    jumpTo(32'd9);
    bus.Halt = 1'b1;
    step();
    clearCtl();
    checkVal("halt_running", 32'(bus.Running), 32'd0);
    checkVal("halt_cnt",     bus.RetireCnt, 32'd14);
    bus.JumpEn     = 1'b1;
    bus.JumpTarget = 32'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      checkVal($sformatf("halted_pc%0d", i), bus.PCOut, 32'd9);
    end
    checkVal("halted_running", 32'(bus.Running), 32'd0);
    clearCtl();
    bus.Resume = 1'b1;
    step();
    clearCtl();
    checkVal("resume_pc",      bus.PCOut, 32'd10);
    checkVal("resume_running", 32'(bus.Running), 32'd1);
    checkVal("resume_cnt",     bus.RetireCnt, 32'd14);

    // Top of ROM: sequential step faults
    jumpTo(32'd31);
    checkVal("pc31", bus.PCOut, 32'd31);
    step();
    checkVal("fault_flag",    32'(bus.Fault), 32'd1);
    checkVal("fault_running", 32'(bus.Running), 32'd0);
    checkVal("fault_pc",      bus.PCOut, 32'd31);
    checkVal("fault_cnt",     bus.RetireCnt, 32'd15);
    bus.Resume = 1'b1;
    step();
    clearCtl();
    checkVal("fault_resume_ign", 32'(bus.Fault), 32'd1);
    checkVal("fault_resume_pc",  bus.PCOut, 32'd31);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkVal("fault_rst_pc",    bus.PCOut, 32'd0);
    checkVal("fault_rst_fault", 32'(bus.Fault), 32'd0);
    checkVal("fault_rst_cnt",   bus.RetireCnt, 32'd0);

    // Negative branch wrapping below zero is out of range
    bus.BranchTaken = 1'b1;
    bus.BranchOff   = 32'hFFFF_FFFF;
    step();
    clearCtl();
    checkVal("wrap_fault", 32'(bus.Fault), 32'd1);
    checkVal("wrap_pc",    bus.PCOut, 32'd0);

    // Resume from halt at the last word faults
    rst = 1'b1;
    step();
    rst = 1'b0;
    jumpTo(32'd31);
    bus.Halt = 1'b1;
    step();
    clearCtl();
    bus.Resume = 1'b1;
    step();
    clearCtl();
    checkVal("halt31_fault", 32'(bus.Fault), 32'd1);
    checkVal("halt31_pc",    bus.PCOut, 32'd31);
    checkVal("halt31_cnt",   bus.RetireCnt, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_fetch_unit
